microcycle_stretch_ctl: RTL
===========================

// Module: microcycle_stretch_ctl
// PURPOSE
//  Sequences one ND-120 microcycle from start to commit.
//  - Adds wait phases for the DLY0/DLY1 requests, computed with the same terms as the CYIN1 PAL.
//  - Holds the cycle while memory/IO wait (HOLD_n) is asserted.
//  - Gates the register-file write strobe with the NOWRIT decode.
//  - Sits between the microinstruction register and the microsequencer advance.
// PARAMETERS
//  BASE_PHASES  2   CLK cycles in an unstretched microcycle (1..15)
//  DLY0_EXTRA   1   extra cycles added when DLY0 is requested
//  DLY1_EXTRA   2   extra cycles added when DLY1 is requested
//  MAX_HOLD     15  HOLD cycles before forced completion (1..255)
// PORTS
//  CLK           in   1  system clock; all state changes on rising edge
//  RST           in   1  synchronous reset, active-high
//  CYC_START     in   1  new microinstruction valid; sampled in IDLE or COMMIT only
//  CSDELAY0      in   1  microcode DLY0 request
//  CSDELAY1      in   1  microcode 25 ns delay field
//  CSALUM        in   2  ALU mode field (bits M1,M0)
//  CSALUI8       in   1  ALU instruction bit 8
//  CSALUI7       in   1  ALU instruction bit 7
//  LBA           in   4  register-file B address
//  RRF_n         in   1  register-file read request, active-low
//  SLCOND_n      in   1  microcode condition, active-low
//  HOLD_n        in   1  memory/IO wait, active-low
//  BUSY          out  1  microcycle in progress (not IDLE)
//  MC_DONE       out  1  one-cycle pulse; microcycle complete, advance uPC
//  WRF_n         out  1  register-file write strobe, active-low, only in COMMIT
//  HOLD_TIMEOUT  out  1  one-cycle pulse in COMMIT when the hold was forced
//  DLY_CNT       out  4  latched extra-cycle count; 0 in IDLE
// BEHAVIOUR
//  Reset: all outputs are registered. RST=1 forces the following on the next edge:
//   - state=IDLE; BUSY=0, MC_DONE=0, WRF_n=1, HOLD_TIMEOUT=0, DLY_CNT=0.
//   - If asserted mid-cycle, the cycle aborts with no MC_DONE and no write.
//  Decode, latched on the accepting edge of CYC_START:
//   - dly1 = (CSDELAY1 & ~LBA[3] & LBA[1] & LBA[0]) | (~RRF_n & ~SLCOND_n)
//   - extra = (CSDELAY0 ? DLY0_EXTRA : 0) + (dly1 ? DLY1_EXTRA : 0), 4-bit, saturates at 15
//   - nowrit = ~CSALUI8 & ~CSALUI7 & (~CSALUM[1] | ~CSALUM[0])
//  Inputs are not re-sampled until the next accepted CYC_START.
//  States:
//   - IDLE:
//     - CYC_START=1 -> BASE with cnt = BASE_PHASES-1.
//   - BASE: cnt decrements each cycle. At cnt=0:
//     - extra>0 -> STRETCH with cnt = extra-1;
//     - else HOLD_n=0 -> HOLD;
//     - else -> COMMIT.
//   - STRETCH: cnt decrements. At cnt=0:
//     - HOLD_n=0 -> HOLD;
//     - else -> COMMIT.
//   - HOLD: hcnt=0 on entry.
//     - HOLD_n=1 -> COMMIT.
//     - Else hcnt=MAX_HOLD-1 -> COMMIT with timeout set.
//     - Else hcnt++.
//   - COMMIT: exactly one cycle.
//     - MC_DONE=1.
//     - WRF_n=0 unless nowrit or timeout.
//     - HOLD_TIMEOUT=timeout.
//     - CYC_START=1 -> BASE (back-to-back, new decode latched); else -> IDLE.
//  CYC_START is ignored in BASE, STRETCH and HOLD.
//  Latency: CYC_START accepted at edge k -> MC_DONE high in cycle k+BASE_PHASES+extra+h+1.
//   - h = number of HOLD cycles.
//  Example: defaults, no delay, no hold -> k+3.
//  HOLD_n is only sampled in the final BASE/STRETCH cycle and in HOLD.
//  DLY_CNT holds the latched extra from acceptance until return to IDLE.
// TESTING
//  1 Defaults, CYC_START at k, no delays, HOLD_n=1, CSALUM=2'b11
//    -> MC_DONE and WRF_n=0 in cycle k+3 only; BUSY k+1..k+3.
//  2 CSDELAY1=1, LBA=4'b0011 -> DLY_CNT=2, MC_DONE at k+5;
//    same with LBA=4'b1011 -> MC_DONE at k+3.
//  3 CSDELAY0=1, RRF_n=0, SLCOND_n=0 -> DLY_CNT=3, MC_DONE at k+6.
//  4 CSALUM=2'b01, CSALUI8=0, CSALUI7=0 -> MC_DONE at k+3, WRF_n stays 1;
//    CSALUI7=1 -> WRF_n=0.
//  5 HOLD_n=0 over k+2..k+5 -> MC_DONE at k+7.
//    HOLD_n=0 for 20 cycles -> MC_DONE, HOLD_TIMEOUT=1, WRF_n=1 at k+18.
//  6 CYC_START held high -> MC_DONE every 3 cycles, BUSY never drops;
//    RST pulsed in STRETCH -> IDLE next cycle, no MC_DONE, WRF_n=1.

Source files
------------

// File: rtl/microcycle_stretch_ctl.sv
// microcycle_stretch_ctl
// Sequences one ND-120 microcycle from acceptance to commit: base phases,
// optional DLY0/DLY1 stretch phases, memory/IO hold with a forced-completion
// limit, and a single commit cycle that gates the register-file write strobe.
// All outputs are registered from the current state, so they appear one
// clock after the state that produces them.

module microcycle_stretch_ctl #(
   parameter int unsigned BASE_PHASES = 2,
   parameter int unsigned DLY0_EXTRA  = 1,
   parameter int unsigned DLY1_EXTRA  = 2,
   parameter int unsigned MAX_HOLD    = 15
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CYC_START,
   input  logic       CSDELAY0,
   input  logic       CSDELAY1,
   input  logic [1:0] CSALUM,
   input  logic       CSALUI8,
   input  logic       CSALUI7,
   input  logic [3:0] LBA,
   input  logic       RRF_n,
   input  logic       SLCOND_n,
   input  logic       HOLD_n,
   output logic       BUSY,
   output logic       MC_DONE,
   output logic       WRF_n,
   output logic       HOLD_TIMEOUT,
   output logic [3:0] DLY_CNT
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_BASE    = 3'd1,
      S_STRETCH = 3'd2,
      S_HOLD    = 3'd3,
      S_COMMIT  = 3'd4
   } state_e;

   // Reload values; extra-cycle amounts are clipped to the 4-bit counter range.
   localparam logic [3:0] BASE_LAST = 4'(BASE_PHASES - 1);
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   localparam logic [4:0] DLY0_W    = 5'((DLY0_EXTRA > 15) ? 15 : DLY0_EXTRA);
   localparam logic [4:0] DLY1_W    = 5'((DLY1_EXTRA > 15) ? 15 : DLY1_EXTRA);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] hcnt_q, hcnt_d;
   logic [3:0] extra_q, extra_d;
   logic       nowrit_q, nowrit_d;
   logic       timeout_q, timeout_d;

   logic       dly1_s;
   logic [4:0] sum_s;
   logic [3:0] extra_s;
   logic       nowrit_s;

   // Microinstruction decode, same product terms as the CYIN1 PAL.
   always_comb begin
      dly1_s   = (CSDELAY1 & ~LBA[3] & LBA[1] & LBA[0]) | (~RRF_n & ~SLCOND_n);
      sum_s    = (CSDELAY0 ? DLY0_W : 5'd0) + (dly1_s ? DLY1_W : 5'd0);
      extra_s  = (sum_s > 5'd15) ? 4'd15 : sum_s[3:0];
      nowrit_s = ~CSALUI8 & ~CSALUI7 & (~CSALUM[1] | ~CSALUM[0]);
   end

   // Next-state logic: phase counting, stretch/hold selection, decode latching.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      extra_d   = extra_q;
      nowrit_d  = nowrit_q;
      timeout_d = timeout_q;
      case (state_q)
         S_IDLE: begin
            if (CYC_START) begin
               state_d   = S_BASE;
               cnt_d     = BASE_LAST;
               extra_d   = extra_s;
               nowrit_d  = nowrit_s;
               timeout_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BASE: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (extra_q != 4'd0) begin
               state_d = S_STRETCH;
               cnt_d   = extra_q - 4'd1;
            end else if (!HOLD_n) begin
               state_d = S_HOLD;
               hcnt_d  = 8'd0;
            end else begin
               state_d = S_COMMIT;
            end
         end
         S_STRETCH: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (!HOLD_n) begin
               state_d = S_HOLD;
               hcnt_d  = 8'd0;
            end else begin
               state_d = S_COMMIT;
            end
         end
         S_HOLD: begin
            if (HOLD_n) begin
               state_d = S_COMMIT;
            end else if (hcnt_q == HOLD_LAST) begin
               state_d   = S_COMMIT;
               timeout_d = 1'b1;
            end else begin
               hcnt_d = hcnt_q + 8'd1;
            end
         end
         S_COMMIT: begin
            // Back-to-back acceptance latches a fresh decode in the commit cycle.
            if (CYC_START) begin
               state_d   = S_BASE;
               cnt_d     = BASE_LAST;
               extra_d   = extra_s;
               nowrit_d  = nowrit_s;
               timeout_d = 1'b0;
            end else begin
               state_d   = S_IDLE;
               timeout_d = 1'b0;
            end
         end
         default: begin
            state_d   = S_IDLE;
            timeout_d = 1'b0;
         end
      endcase
   end

   // State and latched-decode registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         hcnt_q    <= 8'd0;
         extra_q   <= 4'd0;
         nowrit_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         extra_q   <= extra_d;
         nowrit_q  <= nowrit_d;
         timeout_q <= timeout_d;
      end
   end

   // Registered outputs derived from the current state; reset aborts any write.
   always_ff @(posedge CLK) begin
      if (RST) begin
         BUSY         <= 1'b0;
         MC_DONE      <= 1'b0;
         WRF_n        <= 1'b1;
         HOLD_TIMEOUT <= 1'b0;
         DLY_CNT      <= 4'd0;
      end else begin
         BUSY         <= (state_q != S_IDLE);
         MC_DONE      <= (state_q == S_COMMIT);
         WRF_n        <= ~((state_q == S_COMMIT) & ~nowrit_q & ~timeout_q);
         HOLD_TIMEOUT <= (state_q == S_COMMIT) & timeout_q;
         DLY_CNT      <= (state_q == S_IDLE) ? 4'd0 : extra_q;
      end
   end

endmodule
